edge_vga_transmitter: RTL
=========================

EDGE_VGA_TRANSMITTER -- requirements
Module: edge_vga_transmitter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- P_FRAME_COLUMNS, 640: active columns.
- P_FRAME_ROWS, 480: active rows.
- P_H_FRONT, 16 / P_H_SYNC, 96 / P_H_BACK, 48: horizontal porch and sync widths, in pixel ticks.
- P_V_FRONT, 10 / P_V_SYNC, 2 / P_V_BACK, 33: vertical porch and sync widths, in lines.
- P_CLK_DIV, 2: I_CLK cycles per pixel tick; minimum 2.
- P_SUBPIXEL_DEPTH, 8: width of the grayscale edge pixel.
- P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS); P_FRAME_ROW_BITS = $clog2(P_FRAME_ROWS).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- I_CLK, in, 1: the single clock.
- I_RESET_N, in, 1: reset, asynchronous and active-low.
- I_PIXEL_COLUMN, in, P_FRAME_COLUMN_BITS: write column.
- I_PIXEL_ROW, in, P_FRAME_ROW_BITS: write row.
- I_PIXEL, in, P_SUBPIXEL_DEPTH: edge magnitude to store.
- I_PIXEL_VALID, in, 1: write strobe, sampled on every I_CLK.
- I_CLEAR_UNDERRUN, in, 1: clears the sticky underrun flag.
- O_PIXEL_CLK, out, 1: VGA pixel clock.
- O_HSYNC, out, 1: horizontal sync, active-low.
- O_VSYNC, out, 1: vertical sync, active-low.
- O_DATA_VALID, out, 1: high in the active region.
- O_PIXEL, out, 3*P_SUBPIXEL_DEPTH: RGB output, gray value replicated into R, G and B.
- O_LINE_UNDERRUN, out, 1: sticky underrun flag.

Function
REQ-003 The block SHALL generate a one-cycle internal tick every P_CLK_DIV I_CLK cycles, using a divider counter that runs 0..P_CLK_DIV-1 and ticks when it reaches P_CLK_DIV-1.
REQ-004 O_PIXEL_CLK SHALL be registered: high while the divider is < P_CLK_DIV/2 (integer division), low otherwise.
REQ-005 The horizontal counter h SHALL count 0..H_TOTAL-1 on each tick, where H_TOTAL = P_FRAME_COLUMNS + P_H_FRONT + P_H_SYNC + P_H_BACK.
REQ-006 When h wraps to 0, the vertical counter v SHALL advance 0..V_TOTAL-1 and wrap to 0, where V_TOTAL = P_FRAME_ROWS + P_V_FRONT + P_V_SYNC + P_V_BACK.
REQ-007 The horizontal phase SHALL be decoded from h as a four-state machine, with each transition taken on the tick where h crosses the boundary:
- ACTIVE: h < COLUMNS.
- FRONT: COLUMNS <= h < COLUMNS+FRONT.
- SYNC: COLUMNS+FRONT <= h < COLUMNS+FRONT+SYNC.
- BACK: remainder of the line.
The vertical phases SHALL be decoded from v in the same way.
REQ-008 On each tick, all O_HSYNC, O_VSYNC, O_DATA_VALID and O_PIXEL SHALL register the decode of the pre-increment (h,v); no output SHALL change on non-tick cycles.
- O_HSYNC SHALL be 0 iff the horizontal phase is SYNC.
- O_VSYNC SHALL be 0 iff the vertical phase is SYNC.
- O_DATA_VALID SHALL be 1 iff both phases are ACTIVE.
REQ-009 The line buffer SHALL hold 2 banks of P_FRAME_COLUMNS x P_SUBPIXEL_DEPTH.
- Write: on any I_CLK cycle with I_PIXEL_VALID=1 and I_PIXEL_COLUMN < COLUMNS, store I_PIXEL to bank I_PIXEL_ROW[0] at address I_PIXEL_COLUMN.
- A write with I_PIXEL_COLUMN >= COLUMNS SHALL be ignored.
REQ-010 Each bank SHALL have a ready flag and a row tag.
- A write to column COLUMNS-1 SHALL set the flag and load the tag with I_PIXEL_ROW.
REQ-011 At the tick for active (h,v):
- If bank v[0] is ready and its tag equals v, O_PIXEL SHALL be {3{bank[v[0]][h]}}.
- Otherwise O_PIXEL SHALL be 0 and O_LINE_UNDERRUN SHALL be set.
REQ-012 In blanking, O_PIXEL SHALL be 0.
REQ-013 At the tick for active h = COLUMNS-1, the ready flag of bank v[0] SHALL clear.
- If a set for the same bank occurs in the same cycle, the set SHALL win.
REQ-014 A read and a write to the same bank address in the same cycle SHALL return the old data.
REQ-015 O_LINE_UNDERRUN SHALL clear on I_CLEAR_UNDERRUN=1.
- If an underrun and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-016 While I_RESET_N=0, immediately and independent of I_CLK:
- The divider, h and v SHALL be 0.
- Both ready flags and both tags SHALL be 0.
- O_PIXEL_CLK SHALL be 0.
- O_HSYNC and O_VSYNC SHALL be 1.
- O_DATA_VALID, O_PIXEL and O_LINE_UNDERRUN SHALL be 0.
Buffer contents are not reset.
REQ-017 After I_RESET_N rises, the first tick SHALL occur on the P_CLK_DIV-th rising I_CLK edge, and its outputs SHALL describe (h,v) = (0,0).
REQ-018 Reset asserted mid-frame SHALL abandon the frame; the first frame after release SHALL restart at (0,0).

Verification
Bench parameters: COLUMNS=8, ROWS=4, H_FRONT=2, H_SYNC=3, H_BACK=2 (H_TOTAL=15); V_FRONT=1, V_SYNC=2, V_BACK=1 (V_TOTAL=8); CLK_DIV=2; DEPTH=8.
REQ-019 Timing: free-run with no writes -> per line, O_DATA_VALID is high for 8 ticks and O_HSYNC is low for ticks 10-12. O_VSYNC is low for lines 5-6, and the frame is 120 ticks (240 clocks).
REQ-020 Data path: write row 0 with columns 0..7 = 0x10..0x17 before line 0 -> O_PIXEL = 0x101010..0x171717 across line 0, and O_LINE_UNDERRUN stays 0.
REQ-021 Underrun: no write to row 1 -> O_PIXEL = 0 across line 1, and O_LINE_UNDERRUN = 1. It stays 1 until an I_CLEAR_UNDERRUN pulse, then reads 0.
REQ-022 Stale tag: bank 0 still holds row 0 data with its flag set when line 2 displays -> underrun set and O_PIXEL = 0 (the tag mismatches).
REQ-023 Set/clear collision: write column 7 of row 2 in the same cycle as the end-of-line-0 clear of bank 0 -> the bank 0 flag is 1 with tag 2, and line 2 displays correctly.
REQ-024 Reset mid-line: assert I_RESET_N=0 at h=5, v=1 between clock edges -> outputs take their reset values immediately. After release, the first tick shows h=0, v=0 with O_DATA_VALID=1.

Source files
------------

// File: rtl/edge_vga_transmitter.sv
// VGA raster generator that displays grayscale edge magnitudes from a two-bank line buffer.
// A line that is not ready when it is scanned shows black and raises a sticky underrun flag.
module edge_vga_transmitter #(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_H_FRONT           = 16,
  parameter int P_H_SYNC            = 96,
  parameter int P_H_BACK            = 48,
  parameter int P_V_FRONT           = 10,
  parameter int P_V_SYNC            = 2,
  parameter int P_V_BACK            = 33,
  parameter int P_CLK_DIV           = 2,
  parameter int P_SUBPIXEL_DEPTH    = 8,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
  input  logic                            I_CLK,
  input  logic                            I_RESET_N,
  input  logic [P_FRAME_COLUMN_BITS-1:0]  I_PIXEL_COLUMN,
  input  logic [P_FRAME_ROW_BITS-1:0]     I_PIXEL_ROW,
  input  logic [P_SUBPIXEL_DEPTH-1:0]     I_PIXEL,
  input  logic                            I_PIXEL_VALID,
  input  logic                            I_CLEAR_UNDERRUN,
  output logic                            O_PIXEL_CLK,
  output logic                            O_HSYNC,
  output logic                            O_VSYNC,
  output logic                            O_DATA_VALID,
  output logic [3*P_SUBPIXEL_DEPTH-1:0]   O_PIXEL,
  output logic                            O_LINE_UNDERRUN
);
  localparam int H_TOTAL = P_FRAME_COLUMNS + P_H_FRONT + P_H_SYNC + P_H_BACK;
  localparam int V_TOTAL = P_FRAME_ROWS + P_V_FRONT + P_V_SYNC + P_V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int D_W     = $clog2(P_CLK_DIV);
  localparam int DEP     = P_SUBPIXEL_DEPTH;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  // Later boundaries are tested first so a zero-width region is skipped cleanly.
  function automatic phase_e phase_step(phase_e cur, int nxt, int act, int fr, int sy);
    phase_e n;
    n = cur;
    if (nxt == act + fr + sy) n = PH_BACK;
    else if (nxt == act + fr) n = PH_SYNC;
    else if (nxt == act)      n = PH_FRONT;
    else if (nxt == 0)        n = PH_ACTIVE;
    return n;
  endfunction

  logic [D_W-1:0]   div_q, div_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  phase_e           hph_q, hph_d, vph_q, vph_d;
  logic             pclk_q, pclk_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic             dv_q, dv_d, und_q, und_d;
  logic [3*DEP-1:0] pix_q, pix_d;
  logic [1:0]       rdy_q, rdy_d;
  logic [1:0][P_FRAME_ROW_BITS-1:0] tag_q, tag_d;
  logic [DEP-1:0]   mem_q [2][P_FRAME_COLUMNS];

  logic           tick, h_wrap, v_wrap, active, rd_bank, line_ok, eol, wr_en, wr_last;
  logic [DEP-1:0] rd_pix;

  always_comb begin
    tick    = (div_q == D_W'(P_CLK_DIV - 1));
    h_wrap  = (h_q == H_W'(H_TOTAL - 1));
    v_wrap  = (v_q == V_W'(V_TOTAL - 1));
    active  = (hph_q == PH_ACTIVE) && (vph_q == PH_ACTIVE);
    rd_bank = v_q[0];
    rd_pix  = mem_q[rd_bank][h_q[P_FRAME_COLUMN_BITS-1:0]];
    line_ok = rdy_q[rd_bank] && (32'(tag_q[rd_bank]) == 32'(v_q));
    eol     = tick && active && (h_q == H_W'(P_FRAME_COLUMNS - 1));
    wr_en   = I_PIXEL_VALID && (32'(I_PIXEL_COLUMN) < 32'(P_FRAME_COLUMNS));
    wr_last = wr_en && (I_PIXEL_COLUMN == P_FRAME_COLUMN_BITS'(P_FRAME_COLUMNS - 1));
  end

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    hph_d   = hph_q;
    vph_d   = vph_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    dv_d    = dv_q;
    pix_d   = pix_q;
    if (tick) begin
      h_d   = h_wrap ? '0 : h_q + 1'b1;
      hph_d = phase_step(hph_q, int'(h_d), P_FRAME_COLUMNS, P_H_FRONT, P_H_SYNC);
      if (h_wrap) begin
        v_d   = v_wrap ? '0 : v_q + 1'b1;
        vph_d = phase_step(vph_q, int'(v_d), P_FRAME_ROWS, P_V_FRONT, P_V_SYNC);
      end
      // Outputs describe the position before the increment.
      hsync_d = (hph_q != PH_SYNC);
      vsync_d = (vph_q != PH_SYNC);
      dv_d    = active;
      pix_d   = (active && line_ok) ? {3{rd_pix}} : '0;
    end
    pclk_d = (32'(div_d) < 32'(P_CLK_DIV / 2));

    und_d = und_q;
    if (I_CLEAR_UNDERRUN) und_d = 1'b0;
    if (tick && active && !line_ok) und_d = 1'b1;

    // A line consumed at its last column frees the bank; a fresh fill in the same cycle wins.
    rdy_d = rdy_q;
    tag_d = tag_q;
    if (eol) rdy_d[rd_bank] = 1'b0;
    if (wr_last) begin
      rdy_d[I_PIXEL_ROW[0]] = 1'b1;
      tag_d[I_PIXEL_ROW[0]] = I_PIXEL_ROW;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hph_q   <= PH_ACTIVE;
      vph_q   <= PH_ACTIVE;
      pclk_q  <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      dv_q    <= 1'b0;
      pix_q   <= '0;
      und_q   <= 1'b0;
      rdy_q   <= '0;
      tag_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hph_q   <= hph_d;
      vph_q   <= vph_d;
      pclk_q  <= pclk_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      dv_q    <= dv_d;
      pix_q   <= pix_d;
      und_q   <= und_d;
      rdy_q   <= rdy_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (wr_en) mem_q[I_PIXEL_ROW[0]][I_PIXEL_COLUMN] <= I_PIXEL;
  end

  assign O_PIXEL_CLK     = pclk_q;
  assign O_HSYNC         = hsync_q;
  assign O_VSYNC         = vsync_q;
  assign O_DATA_VALID    = dv_q;
  assign O_PIXEL         = pix_q;
  assign O_LINE_UNDERRUN = und_q;
endmodule
